// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants, renderer colours and playfield geometry
// for the breakout display path.
package vga_timing_pkg;

    localparam int VGA_CLK_DIV      = 4;
    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_DISP_START = 144;
    localparam int VGA_H_DISP_END   = 784;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_DISP_START = 35;
    localparam int VGA_V_DISP_END   = 515;

    localparam logic [11:0] RED          = 12'hF00;
    localparam logic [11:0] WHITE        = 12'hFFF;
    localparam logic [11:0] PINK         = 12'hF6B;
    localparam logic [11:0] BLUE         = 12'h00F;
    localparam logic [11:0] PURPLE       = 12'h80F;
    localparam logic [11:0] BRIGHT_GREEN = 12'h0F0;
    localparam logic [11:0] BLACK        = 12'h000;

    // Playfield edges in raster coordinates (inside the visible window)
    localparam int WALL_LEFT_X  = 164;
    localparam int WALL_RIGHT_X = 764;
    localparam int CEILING_Y    = 55;
    localparam int FLOOR_Y      = 495;

    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic bright;
    } vga_flags_t;

    function automatic logic in_window(input logic [10:0] val,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_en_div.sv
// Clock divider producing a registered one-clk pixel enable every CLK_DIV cycles.
module pix_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;

    // pix_en is decoded from the next divider value so it lines up with div==CLK_DIV-1
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_en_d = (div_d == DIV_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
        end
    end

    assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, registered syncs/bright, frame_start and game_tick.
// Optional free-running frame counter enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV          = VGA_CLK_DIV,
    parameter int H_TOTAL          = VGA_H_TOTAL,
    parameter int H_SYNC           = VGA_H_SYNC,
    parameter int H_DISP_START     = VGA_H_DISP_START,
    parameter int H_DISP_END       = VGA_H_DISP_END,
    parameter int V_TOTAL          = VGA_V_TOTAL,
    parameter int V_SYNC           = VGA_V_SYNC,
    parameter int V_DISP_START     = VGA_V_DISP_START,
    parameter int V_DISP_END       = VGA_V_DISP_END,
    parameter int GAME_TICK_FRAMES = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        frame_start,
    output logic        game_tick,
    output logic [15:0] frame_cnt
);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be in 1..1024");
    end
    if (CLK_DIV < 1 || GAME_TICK_FRAMES < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV and GAME_TICK_FRAMES must be >= 1");
    end

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_SY_W  = 11'(H_SYNC);
    localparam logic [10:0] V_SY_W  = 11'(V_SYNC);
    localparam logic [10:0] H_DS_W  = 11'(H_DISP_START);
    localparam logic [10:0] H_DE_W  = 11'(H_DISP_END);
    localparam logic [10:0] V_DS_W  = 11'(V_DISP_START);
    localparam logic [10:0] V_DE_W  = 11'(V_DISP_END);
    localparam int          TICK_W  = (GAME_TICK_FRAMES > 1) ? $clog2(GAME_TICK_FRAMES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(GAME_TICK_FRAMES - 1);

    logic              pix_en_w;
    logic [9:0]        h_q, h_d, v_q, v_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              frame_start_q, frame_start_d;
    logic              game_tick_q, game_tick_d;
    vga_flags_t        flags_q, flags_d;

    pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en_w)
    );

    // Flags and pulses are derived from the next counts so they register together
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        tick_d        = tick_q;
        frame_start_d = 1'b0;
        game_tick_d   = 1'b0;
        if (pix_en_w) begin
            if (h_q == H_LAST) begin
                h_d           = '0;
                v_d           = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                frame_start_d = (v_q == V_LAST);
                if ({1'b0, v_d} == V_DE_W) begin
                    game_tick_d = (tick_q == TICK_LAST);
                    tick_d      = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        flags_d.h_sync = !({1'b0, h_d} < H_SY_W);
        flags_d.v_sync = !({1'b0, v_d} < V_SY_W);
        flags_d.bright = in_window({1'b0, h_d}, H_DS_W, H_DE_W) &&
                         in_window({1'b0, v_d}, V_DS_W, V_DE_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            tick_q        <= '0;
            frame_start_q <= 1'b0;
            game_tick_q   <= 1'b0;
            flags_q       <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            tick_q        <= tick_d;
            frame_start_q <= frame_start_d;
            game_tick_q   <= game_tick_d;
            flags_q       <= flags_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_start_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign pix_en      = pix_en_w;
    assign hCount      = h_q;
    assign vCount      = v_q;
    assign hSync       = flags_q.h_sync;
    assign vSync       = flags_q.v_sync;
    assign bright      = flags_q.bright;
    assign frame_start = frame_start_q;
    assign game_tick   = game_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken-raster instance for frame-level behaviour and a
// default-parameter instance for the 640x480 divider and line timing.
module tb_vga_timing_gen;

    typedef struct {
        int cd, ht, hsw, hds, hde, vt, vsw, vds, vde, gtf;
    } cfg_t;

    typedef struct {
        int pix_en, h, v, hs, vs, br, fs, gt, fc;
    } exp_t;

    localparam cfg_t CFG_S = '{4, 20, 3, 5, 17, 12, 2, 3, 10, 3};
    localparam cfg_t CFG_D = '{4, 800, 96, 144, 784, 525, 2, 35, 515, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          t;
    int          errors = 0;
    int          checks = 0;

    logic        s_pe, s_hs, s_vs, s_br, s_fs, s_gt;
    logic [9:0]  s_h, s_v;
    logic [15:0] s_fc;
    logic        d_pe, d_hs, d_vs, d_br, d_fs, d_gt;
    logic [9:0]  d_h, d_v;
    logic [15:0] d_fc;

    int s_bright_cnt = 0;
    int s_vs_low_cnt = 0;
    int s_fs_cnt     = 0;
    int s_gt_cnt     = 0;
    int d_hs_low_cnt = 0;

    vga_timing_gen #(
        .CLK_DIV          (4),
        .H_TOTAL          (20),
        .H_SYNC           (3),
        .H_DISP_START     (5),
        .H_DISP_END       (17),
        .V_TOTAL          (12),
        .V_SYNC           (2),
        .V_DISP_START     (3),
        .V_DISP_END       (10),
        .GAME_TICK_FRAMES (3)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (s_pe),
        .hCount      (s_h),
        .vCount      (s_v),
        .hSync       (s_hs),
        .vSync       (s_vs),
        .bright      (s_br),
        .frame_start (s_fs),
        .game_tick   (s_gt),
        .frame_cnt   (s_fc)
    );

    vga_timing_gen dut_d (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (d_pe),
        .hCount      (d_h),
        .vCount      (d_v),
        .hSync       (d_hs),
        .vSync       (d_vs),
        .bright      (d_br),
        .frame_start (d_fs),
        .game_tick   (d_gt),
        .frame_cnt   (d_fc)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // t counts clk cycles since the last reset release (cycle 0 = first cycle after release)
    always @(posedge clk or posedge rst) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    // Raster model: the output state at cycle t follows from how many pixels have elapsed
    function automatic exp_t model(input int tt, input cfg_t c);
        exp_t e;
        int n, ph, hv, f, pos;
        n   = tt / c.cd;
        ph  = tt % c.cd;
        hv  = c.ht * c.vt;
        f   = n / hv;
        pos = n % hv;
        e.pix_en = (ph == c.cd - 1) ? 1 : 0;
        e.h  = pos % c.ht;
        e.v  = pos / c.ht;
        e.hs = (e.h >= c.hsw) ? 1 : 0;
        e.vs = (e.v >= c.vsw) ? 1 : 0;
        e.br = (e.h >= c.hds && e.h < c.hde && e.v >= c.vds && e.v < c.vde) ? 1 : 0;
        e.fs = (ph == 0 && pos == 0 && n > 0) ? 1 : 0;
        e.gt = (ph == 0 && e.h == 0 && e.v == c.vde && (f % c.gtf) == c.gtf - 1) ? 1 : 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fc = (tt == 0) ? 0 : (((tt - 1) / (c.cd * hv)) & 16'hFFFF);
`else
        e.fc = 0;
`endif
        return e;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s t=%0d got=%0d want=%0d", name, t, actual, expected);
        end
    endtask

    task automatic compareDut(input string tag, input cfg_t c, input logic pe,
                              input logic [9:0] h, input logic [9:0] v,
                              input logic hs, input logic vs, input logic br,
                              input logic fs, input logic gt, input logic [15:0] fc);
        exp_t e;
        e = model(t, c);
        checkOutput({tag, "_pix_en"}, pe, e.pix_en);
        checkOutput({tag, "_hCount"}, h, e.h);
        checkOutput({tag, "_vCount"}, v, e.v);
        checkOutput({tag, "_hSync"}, hs, e.hs);
        checkOutput({tag, "_vSync"}, vs, e.vs);
        checkOutput({tag, "_bright"}, br, e.br);
        checkOutput({tag, "_frame_start"}, fs, e.fs);
        checkOutput({tag, "_game_tick"}, gt, e.gt);
        checkOutput({tag, "_frame_cnt"}, fc, e.fc);
    endtask

    // Per-cycle compare against the model plus window counters, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            compareDut("s", CFG_S, s_pe, s_h, s_v, s_hs, s_vs, s_br, s_fs, s_gt, s_fc);
            compareDut("d", CFG_D, d_pe, d_h, d_v, d_hs, d_vs, d_br, d_fs, d_gt, d_fc);
            if (t >= 960 && t < 1920) begin
                if (s_pe && s_br) s_bright_cnt++;
                if (!s_vs)        s_vs_low_cnt++;
            end
            if (s_fs) s_fs_cnt++;
            if (s_gt) s_gt_cnt++;
            if (d_v == 10'd11 && !d_hs) d_hs_low_cnt++;
        end
    end

    task automatic waitT(input int target);
        int guard = 0;
        while (t < target && guard < 100000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        checkOutput("wait_t", t, target);
    endtask

    task automatic applyStimulus();
        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_d_all", {d_pe, d_h, d_v, d_hs, d_vs, d_br, d_fs, d_gt, d_fc}, 0);
        checkOutput("rst_s_all", {s_pe, s_h, s_v, s_hs, s_vs, s_br, s_fs, s_gt, s_fc}, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int k = 0; k <= 12; k++) begin
            waitT(k);
            checkOutput("d_pix_en_pin", d_pe, (k == 3 || k == 7 || k == 11) ? 1 : 0);
        end
        checkOutput("d_h_at_12", d_h, 3);

        waitT(256);  checkOutput("s_bright_143_35", s_br, 0);
        waitT(260);  checkOutput("s_bright_144_35", s_br, 1);
        waitT(308);  checkOutput("s_bright_784_35", s_br, 0);
        waitT(820);  checkOutput("s_bright_144_515", s_br, 0);
        waitT(959);
        checkOutput("s_h_before_wrap", s_h, 19);
        checkOutput("s_v_before_wrap", s_v, 11);
        waitT(960);
        checkOutput("s_h_frame_wrap", s_h, 0);
        checkOutput("s_v_frame_wrap", s_v, 0);
        checkOutput("s_frame_start_hi", s_fs, 1);
        waitT(961);
        checkOutput("s_frame_start_lo", s_fs, 0);
        waitT(2000);
        checkOutput("s_bright_per_frame", s_bright_cnt, 84);
        checkOutput("s_vsync_low_clk", s_vs_low_cnt, 160);
        waitT(2720);
        checkOutput("s_game_tick_hi", s_gt, 1);
        checkOutput("s_game_tick_v", s_v, 10);
        waitT(2721);
        checkOutput("s_game_tick_lo", s_gt, 0);
        waitT(2881);
`ifdef VGA_TIMING_FRAME_CNT_EN
        checkOutput("s_frame_cnt_3", s_fc, 3);
`else
        checkOutput("s_frame_cnt_off", s_fc, 0);
`endif
        waitT(35199);
        checkOutput("d_h_799", d_h, 799);
        checkOutput("d_v_10", d_v, 10);
        waitT(35200);
        checkOutput("d_h_line_wrap", d_h, 0);
        checkOutput("d_v_line_wrap", d_v, 11);
        waitT(38500);
        checkOutput("d_hsync_low_clk", d_hs_low_cnt, 384);

        // Mid-frame reset: small raster sits at (10,6) here
        waitT(39881);
        checkOutput("s_h_pre_reset", s_h, 10);
        checkOutput("s_v_pre_reset", s_v, 6);
        checkOutput("s_frame_start_total", s_fs_cnt, 41);
        checkOutput("s_game_tick_total", s_gt_cnt, 13);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_s_all", {s_pe, s_h, s_v, s_hs, s_vs, s_br, s_fs, s_gt, s_fc}, 0);
        checkOutput("mid_rst_d_all", {d_pe, d_h, d_v, d_hs, d_vs, d_br, d_fs, d_gt, d_fc}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        waitT(0);
        checkOutput("s_restart_h", s_h, 0);
        checkOutput("s_restart_fs", s_fs, 0);
        waitT(2);    checkOutput("s_restart_pe_2", s_pe, 0);
        waitT(3);    checkOutput("s_restart_pe_3", s_pe, 1);
        waitT(4);
        checkOutput("s_restart_h_4", s_h, 1);
        checkOutput("s_restart_v_4", s_v, 0);
        waitT(3000);
    endtask

    initial begin
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog t=%0d", t);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
